alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Each operation runs IDLE (grant) -> EXEC (ALU evaluates latched operands) -> DONE (ack pulse).
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] res_data,
    output logic              res_of,
    output logic              res_id,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_of,
    output logic [CNT_W-1:0]  of_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [1:0]        op_q;
    logic              winner_q;
    logic              last_grant;
    logic              grant;
    logic              grant_id;

    // Next-state and arbitration; on a tie the requester that did not win last time goes first.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    grant_id   = (req0 && req1) ? ~last_grant : req1;
                    next_state = EXEC;
                end
            end
            EXEC:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operands are frozen at the grant edge so the ALU inputs never follow the request ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= 2'b00;
            winner_q   <= 1'b0;
            last_grant <= 1'b1;
            res_data   <= '0;
            res_of     <= 1'b0;
            res_id     <= 1'b0;
            of_count   <= '0;
        end else begin
            if (grant) begin
                opa_q      <= grant_id ? a1 : a0;
                opb_q      <= grant_id ? b1 : b0;
                op_q       <= grant_id ? op1 : op0;
                winner_q   <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                res_data <= alu_result;
                res_of   <= alu_of;
                res_id   <= winner_q;
            end
            if (state == DONE && res_of && of_count != '1) begin
                of_count <= of_count + 1'b1;
            end
        end
    end

    assign ack0   = (state == DONE) && !res_id;
    assign ack1   = (state == DONE) && res_id;
    assign busy   = (state != IDLE);
    assign alu_a  = opa_q;
    assign alu_b  = opb_q;
    assign alu_op = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors push expected results, a monitor
// pops and compares on every ack. The bench also supplies the shared combinational ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic        ack0, ack1;
    logic [15:0] res_data;
    logic        res_of;
    logic        res_id;
    logic        busy;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_of;
    logic [7:0]  of_count;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        of;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   popped     = 0;

    alu_arbiter #(.DATA_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .ack0(ack0), .ack1(ack1),
        .res_data(res_data), .res_of(res_of), .res_id(res_id),
        .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_of(alu_of),
        .of_count(of_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: any overflow, underflow or divide-by-zero returns 0 with the flag set.
    always_comb begin
        logic [31:0] wide;
        alu_result = '0;
        alu_of     = 1'b0;
        wide       = '0;
        case (alu_op)
            2'b00: wide = {16'h0, alu_a} + {16'h0, alu_b};
            2'b01: wide = (alu_a < alu_b) ? 32'h10000 : {16'h0, alu_a - alu_b};
            2'b10: wide = {16'h0, alu_a} * {16'h0, alu_b};
            2'b11: wide = (alu_b == 0) ? 32'h10000 : {16'h0, alu_a / alu_b};
            default: wide = '0;
        endcase
        if (wide[31:16] != 0) begin
            alu_of = 1'b1;
        end else begin
            alu_result = wide[15:0];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic id, input logic [15:0] data, input logic of);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.of   = of;
        sb.push_back(e);
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_ack: got ack1/ack0=%b%b, expected none at %0t",
                         ack1, ack0, $time);
            end else begin
                mon_e = sb.pop_front();
                check_output("ack_onehot", {30'h0, ack1, ack0}, mon_e.id ? 32'd2 : 32'd1);
                check_output("res_id", {31'h0, res_id}, {31'h0, mon_e.id});
                check_output("res_data", {16'h0, res_data}, {16'h0, mon_e.data});
                check_output("res_of", {31'h0, res_of}, {31'h0, mon_e.of});
            end
            popped++;
        end
    end

    // Returns mid-way through the DONE cycle of the n-th further ack, or flags a timeout.
    task automatic wait_acks(input int n);
        int target;
        int cycles;
        target = popped + n;
        cycles = 0;
        while (popped < target && cycles < 10 * n + 20) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        compared++;
        if (popped < target) begin
            mismatched++;
            $display("[TB] FAIL ack_timeout: got %0d acks, expected %0d", popped, target);
        end
    endtask

    task automatic apply_stimulus_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_ack", {30'h0, ack1, ack0}, 0);
        check_output("rst_busy", {31'h0, busy}, 0);
        check_output("rst_res_data", {16'h0, res_data}, 0);
        check_output("rst_res_of_id", {30'h0, res_of, res_id}, 0);
        check_output("rst_alu", {14'h0, alu_op, alu_a}, 0);
        check_output("rst_of_count", {24'h0, of_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 0: 5 + 3, ack in the third cycle.
        @(negedge clk);
        req0 = 1; a0 = 16'd5; b0 = 16'd3; op0 = 2'b00;
        push_exp(1'b0, 16'd8, 1'b0);
        @(posedge clk); #1;
        req0 = 0; a0 = 16'd0;
        check_output("exec_busy", {31'h0, busy}, 1);
        check_output("exec_ack", {30'h0, ack1, ack0}, 0);
        check_output("exec_alu_a", {16'h0, alu_a}, 5);
        @(posedge clk); #1;
        check_output("latency_ack0", {30'h0, ack1, ack0}, 1);
        @(posedge clk); #1;
        check_output("idle_ack", {30'h0, ack1, ack0}, 0);
        check_output("idle_busy", {31'h0, busy}, 0);
        check_output("idle_alu_a_held", {16'h0, alu_a}, 5);
        check_output("res_data_held", {16'h0, res_data}, 8);

        // Both requesting from reset release: requester 0 wins the first tie.
        rst_n = 1'b0;
        req0 = 1; a0 = 16'd10; b0 = 16'd4; op0 = 2'b01;
        req1 = 1; a1 = 16'd2;  b1 = 16'd7; op1 = 2'b01;
        push_exp(1'b0, 16'd6, 1'b0);
        push_exp(1'b1, 16'd0, 1'b1);
        apply_stimulus_reset();
        wait_acks(2);
        req0 = 0; req1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("of_count_tie", {24'h0, of_count}, 1);

        // Requester 1: multiply overflow, then held through ack to issue a divide by zero.
        rst_n = 1'b0;
        req1 = 1; a1 = 16'hFFFF; b1 = 16'd2; op1 = 2'b10;
        push_exp(1'b1, 16'd0, 1'b1);
        apply_stimulus_reset();
        wait_acks(1);
        a1 = 16'd100; b1 = 16'd0; op1 = 2'b11;
        push_exp(1'b1, 16'd0, 1'b1);
        wait_acks(1);
        req1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("of_count_req1", {24'h0, of_count}, 2);

        // Both held for six operations: strict alternation with one idle cycle between.
        rst_n = 1'b0;
        req0 = 1; a0 = 16'd1;  b0 = 16'd2;  op0 = 2'b00;
        req1 = 1; a1 = 16'd10; b1 = 16'd20; op1 = 2'b00;
        for (int i = 0; i < 6; i++) begin
            push_exp(i[0], i[0] ? 16'd30 : 16'd3, 1'b0);
        end
        apply_stimulus_reset();
        for (int i = 0; i < 6; i++) begin
            wait_acks(1);
            if (i == 5) begin
                req0 = 0; req1 = 0;
            end
            @(posedge clk); #1;
            check_output("rr_gap_busy", {31'h0, busy}, 0);
            @(posedge clk); #1;
            check_output("rr_next_busy", {31'h0, busy}, (i == 5) ? 0 : 1);
        end

        // Operand change and request drop after grant must not disturb the operation.
        @(negedge clk);
        req0 = 1; a0 = 16'd9; b0 = 16'd4; op0 = 2'b01;
        push_exp(1'b0, 16'd5, 1'b0);
        @(posedge clk); #1;
        a0 = 16'd100; req0 = 0;
        wait_acks(1);

        // Reset during EXEC aborts with no ack.
        @(negedge clk);
        req0 = 1; a0 = 16'hFFFF; b0 = 16'hFFFF; op0 = 2'b10;
        @(posedge clk); #1;
        req0 = 0;
        check_output("abort_pre_busy", {31'h0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", {31'h0, busy}, 0);
        check_output("abort_ack", {30'h0, ack1, ack0}, 0);
        check_output("abort_alu", {14'h0, alu_op, alu_a}, 0);
        check_output("abort_res", {15'h0, res_of, res_data}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("abort_idle_busy", {31'h0, busy}, 0);
        check_output("abort_of_count", {24'h0, of_count}, 0);

        // Saturation: 257 overflowing operations leave the counter at all-ones.
        @(negedge clk);
        req0 = 1;
        for (int i = 0; i < 257; i++) begin
            push_exp(1'b0, 16'd0, 1'b1);
        end
        wait_acks(257);
        req0 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("of_count_sat", {24'h0, of_count}, 32'hFF);
        check_output("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
